padding: RTL and testbench
==========================

PADDING -- requirements
Module: padding

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bit width of one pixel/channel word.
REQ-002 Parameter IMG_WIDTH, default 4: unpadded image width in pixels.
REQ-003 Parameter IMG_HEIGHT, default 3: unpadded image height in pixels.
REQ-004 Parameter PADDING_WIDTH, default 1: zero columns added on each of left and right; 0 allowed.
REQ-005 Parameter PADDING_HEIGHT, default 1: zero rows added on each of top and bottom; 0 allowed.
REQ-006 Parameter CHANNELS, default 2: channels per pixel, streamed sequentially (not unrolled).
REQ-007 Port clk, input, 1: single clock; all state on rising edge.
REQ-008 Port rst, input, 1: reset, asynchronous, active-low.
REQ-009 Port data_in, input, DATA_WIDTH: input word, raster order, channel fastest, then x, then y.
REQ-010 Port data_in_valid, input, 1: upstream word valid.
REQ-011 Port data_in_ready, output, 1: block accepts data_in this cycle.
REQ-012 Port data_out, output, DATA_WIDTH: padded-stream word.
REQ-013 Port data_out_valid, output, 1: data_out valid.
REQ-014 Port data_out_ready, input, 1: downstream accepts data_out.

Function
REQ-015 Output frame: PH = IMG_HEIGHT+2*PADDING_HEIGHT rows, PW = IMG_WIDTH+2*PADDING_WIDTH columns, CHANNELS words per pixel, same ordering as input.
REQ-016 Internal output counters out_c (0..CHANNELS-1), out_x (0..PW-1), out_y (0..PH-1), each sized to hold its maximum value.
REQ-017 Position is interior when PADDING_WIDTH <= out_x < PADDING_WIDTH+IMG_WIDTH and PADDING_HEIGHT <= out_y < PADDING_HEIGHT+IMG_HEIGHT; otherwise padding.
REQ-018 Interior: data_out = data_in, data_out_valid = data_in_valid, data_in_ready = data_out_ready, all combinational (zero latency, no storage).
REQ-019 Padding: data_out = 0, data_out_valid = 1, data_in_ready = 0; no input word consumed.
REQ-020 Counters advance only on output handshake (data_out_valid && data_out_ready); otherwise hold, and data_out stays stable under backpressure.
REQ-021 Advance order: out_c increments; at CHANNELS-1 it wraps to 0 and out_x increments; at PW-1 out_x wraps to 0 and out_y increments.
REQ-022 Handshake on last word (out_y=PH-1, out_x=PW-1, out_c=CHANNELS-1) resets all counters to 0; next frame starts immediately, no idle cycle.
REQ-023 Each frame consumes exactly IMG_HEIGHT*IMG_WIDTH*CHANNELS input words and emits exactly PH*PW*CHANNELS output words.
REQ-024 PADDING_WIDTH = PADDING_HEIGHT = 0: pure combinational pass-through; counters still track position.
REQ-025 In a padding position, data_in_valid is ignored; upstream waits with data_in_ready low.

Reset
REQ-026 rst low asynchronously clears out_c, out_x, out_y to 0 regardless of clk.
REQ-027 While rst low: data_out_valid = 0, data_in_ready = 0, data_out = 0.
REQ-028 After rst released, first output word is position (0,0,0); reset mid-frame discards the partial frame, no words replayed.

Verification
REQ-029 IMG 2x2, CHANNELS=1, pad 1/1, inputs 1,2,3,4, ready always 1 -> 16 outputs 0,0,0,0,0,1,2,0,0,3,4,0,0,0,0,0; data_in_ready high only on beats 6,7,10,11.
REQ-030 Same config, data_out_ready toggled 1/0 -> identical sequence, counters and data_out hold during ready=0, no loss or duplication.
REQ-031 Same config, data_in_valid held 0 -> exactly 5 zero words emitted, then stall (valid low) at interior position (1,1) until input arrives.
REQ-032 IMG 4x3, CHANNELS=2, pad 1/1 -> 6x5x2=60 outputs per frame, 24 inputs consumed; two back-to-back frames with no gap.
REQ-033 Pad 0/0 -> data_out tracks data_in and data_out_valid tracks data_in_valid in the same cycle.
REQ-034 Assert rst low mid-frame (e.g. after 7 outputs) -> valid/ready go 0 immediately; after release output restarts at zero-padding position (0,0,0).

Source files
------------

// File: rtl/padding.sv
// padding: inserts zero-valued borders around a streamed image frame.
//
// The output stream walks a (IMG_HEIGHT + 2*PADDING_HEIGHT) x (IMG_WIDTH + 2*PADDING_WIDTH)
// grid with CHANNELS words per pixel, in the order channel, then column, then row.
// Interior positions forward the input stream combinationally (zero latency, no storage).
// Border positions emit zero words without consuming any input.
//
// Ports
//   clk            : clock; all state updates on the rising edge
//   rst            : asynchronous active-low reset
//   data_in        : input word (raster order, channel fastest)
//   data_in_valid  : upstream word valid
//   data_in_ready  : block accepts data_in this cycle
//   data_out       : padded-stream word
//   data_out_valid : data_out valid
//   data_out_ready : downstream accepts data_out
module padding #(
  parameter int DATA_WIDTH     = 32,
  parameter int IMG_WIDTH      = 4,
  parameter int IMG_HEIGHT     = 3,
  parameter int PADDING_WIDTH  = 1,
  parameter int PADDING_HEIGHT = 1,
  parameter int CHANNELS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int PW = IMG_WIDTH + 2 * PADDING_WIDTH;
  localparam int PH = IMG_HEIGHT + 2 * PADDING_HEIGHT;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int XW = (PW > 1) ? $clog2(PW) : 1;
  localparam int YW = (PH > 1) ? $clog2(PH) : 1;

  logic [CW-1:0] r_out_c;
  logic [XW-1:0] r_out_x;
  logic [YW-1:0] r_out_y;

  int   w_x;
  int   w_y;
  logic w_interior;
  logic w_fire;
  logic w_last_c;
  logic w_last_x;
  logic w_last_y;

  // Signed integer views keep the window compares well-formed when a padding width is zero.
  assign w_x = int'(r_out_x);
  assign w_y = int'(r_out_y);

  assign w_interior = (w_x >= PADDING_WIDTH) && (w_x < PADDING_WIDTH + IMG_WIDTH) &&
                      (w_y >= PADDING_HEIGHT) && (w_y < PADDING_HEIGHT + IMG_HEIGHT);

  assign w_last_c = (r_out_c == CW'(CHANNELS - 1));
  assign w_last_x = (r_out_x == XW'(PW - 1));
  assign w_last_y = (r_out_y == YW'(PH - 1));

  always_comb begin
    data_out       = '0;
    data_out_valid = 1'b0;
    data_in_ready  = 1'b0;
    if (!rst) begin
      // Held quiet while in reset.
      data_out       = '0;
      data_out_valid = 1'b0;
      data_in_ready  = 1'b0;
    end else if (w_interior) begin
      data_out       = data_in;
      data_out_valid = data_in_valid;
      data_in_ready  = data_out_ready;
    end else begin
      // Border: zero word always available, input stalled.
      data_out       = '0;
      data_out_valid = 1'b1;
      data_in_ready  = 1'b0;
    end
  end

  assign w_fire = data_out_valid && data_out_ready;

  // Position advances only on an output handshake; the final word of a frame
  // wraps every counter so the next frame starts on the following beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_c <= '0;
      r_out_x <= '0;
      r_out_y <= '0;
    end else if (w_fire) begin
      if (w_last_c) begin
        r_out_c <= '0;
        if (w_last_x) begin
          r_out_x <= '0;
          if (w_last_y) begin
            r_out_y <= '0;
          end else begin
            r_out_y <= r_out_y + YW'(1);
          end
        end else begin
          r_out_x <= r_out_x + XW'(1);
        end
      end else begin
        r_out_c <= r_out_c + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_padding.sv
module tb_padding;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 2x2 image, 1 channel, pad 1/1, 8-bit ----------------
  logic       a_rst;
  logic [7:0] a_in;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [7:0] a_out;
  logic       a_out_valid;
  logic       a_out_ready;

  padding #(
    .DATA_WIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2),
    .PADDING_WIDTH(1), .PADDING_HEIGHT(1), .CHANNELS(1)
  ) u_a (
    .clk(clk), .rst(a_rst),
    .data_in(a_in), .data_in_valid(a_in_valid), .data_in_ready(a_in_ready),
    .data_out(a_out), .data_out_valid(a_out_valid), .data_out_ready(a_out_ready)
  );

  // ---------------- DUT B: default 4x3, 2 channels, pad 1/1, 32-bit ------------
  logic        b_rst;
  logic [31:0] b_in;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [31:0] b_out;
  logic        b_out_valid;
  logic        b_out_ready;

  padding u_b (
    .clk(clk), .rst(b_rst),
    .data_in(b_in), .data_in_valid(b_in_valid), .data_in_ready(b_in_ready),
    .data_out(b_out), .data_out_valid(b_out_valid), .data_out_ready(b_out_ready)
  );

  // ---------------- DUT C: 3x2, 2 channels, pad 0/0, 16-bit --------------------
  logic        c_rst;
  logic [15:0] c_in;
  logic        c_in_valid;
  logic        c_in_ready;
  logic [15:0] c_out;
  logic        c_out_valid;
  logic        c_out_ready;

  padding #(
    .DATA_WIDTH(16), .IMG_WIDTH(3), .IMG_HEIGHT(2),
    .PADDING_WIDTH(0), .PADDING_HEIGHT(0), .CHANNELS(2)
  ) u_c (
    .clk(clk), .rst(c_rst),
    .data_in(c_in), .data_in_valid(c_in_valid), .data_in_ready(c_in_ready),
    .data_out(c_out), .data_out_valid(c_out_valid), .data_out_ready(c_out_ready)
  );

  // ---------------- DUT A directed vectors -------------------------------------
  logic [7:0] a_exp [16] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0,
                             8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
  logic       a_rdy [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Entered and left at #1 after a rising edge.
  task automatic run_frame_a(input bit toggle, input int nbeats);
    int         beat = 0;
    int         in_idx = 0;
    int         cyc = 0;
    bit         held = 1'b0;
    logic [7:0] held_data = '0;
    while (beat < nbeats && cyc < 200) begin
      a_in_valid  = (in_idx < 4);
      a_in        = 8'(in_idx + 1);
      a_out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(negedge clk);
      if (held) begin
        chk("a_hold_valid", a_out_valid, 1'b1);
        chk("a_hold_data", a_out, held_data);
      end
      if (a_out_valid) begin
        chk("a_in_ready", a_in_ready, a_out_ready & a_rdy[beat]);
        if (a_out_ready) begin
          chk($sformatf("a_data[%0d]", beat), a_out, a_exp[beat]);
          if (a_in_ready && a_in_valid) in_idx++;
          beat++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_data = a_out;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("a_beats_done", 64'(beat), 64'(nbeats));
    if (nbeats == 16) chk("a_inputs_used", 64'(in_idx), 64'd4);
  endtask

  task automatic reset_a();
    a_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b1;
  endtask

  // ---------------- DUT B model and scoreboard ---------------------------------
  function automatic logic [31:0] src_word(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  // Interior test from frame index k using the 6x5 grid, 2 channels per pixel.
  function automatic bit b_interior(input int k);
    int x = (k / 2) % 6;
    int y = k / 12;
    return (x >= 1) && (x < 5) && (y >= 1) && (y < 4);
  endfunction

  bit          b_active = 1'b0;
  bit          b_done = 1'b0;
  bit          b_finished = 1'b0;
  int          b_k = 0;
  int          b_mi = 0;
  int          b_outs = 0;
  int          b_src_idx = 0;
  logic [31:0] b_log [120];

  always @(negedge clk) begin
    if (b_active && !b_done) begin
      bit   inner;
      logic e_valid;
      inner   = b_interior(b_k);
      e_valid = inner ? b_in_valid : 1'b1;
      chk("b_valid", b_out_valid, e_valid);
      chk("b_in_ready", b_in_ready, inner ? b_out_ready : 1'b0);
      if (e_valid) chk("b_data", b_out, inner ? src_word(b_mi) : 32'h0);
      if (e_valid && b_out_ready) begin
        b_log[b_outs] = b_out;
        b_outs++;
        if (inner) b_mi++;
        b_k = (b_k + 1) % 60;
        if (b_outs == 120) b_done = 1'b1;
      end
    end
  end

  initial begin
    bit take;
    b_rst       = 1'b0;
    b_in_valid  = 1'b1;
    b_in        = 32'hFFFF_FFFF;
    b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("b_rst_valid", b_out_valid, 1'b0);
    chk("b_rst_in_ready", b_in_ready, 1'b0);
    chk("b_rst_data", b_out, 32'h0);
    b_rst       = 1'b1;
    b_in        = src_word(0);
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    b_active    = 1'b1;
    for (int cyc = 0; cyc < 1500 && !b_done; cyc++) begin
      @(negedge clk);
      take = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
      if (take) b_src_idx++;
      b_out_ready = (cyc % 5) != 3;
      b_in_valid  = (b_src_idx < 48) && ((cyc % 7) != 2);
      b_in        = src_word(b_src_idx);
    end
    b_out_ready = 1'b0;
    b_finished  = 1'b1;
  end

  // ---------------- Main sequence ----------------------------------------------
  initial begin
    int cnt;
    a_rst = 1'b0; a_in = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    c_rst = 1'b0; c_in = 16'h5A5A; c_in_valid = 1'b1; c_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("a_rst_valid", a_out_valid, 1'b0);
    chk("a_rst_in_ready", a_in_ready, 1'b0);
    chk("a_rst_data", a_out, 8'h0);
    chk("c_rst_valid", c_out_valid, 1'b0);
    chk("c_rst_in_ready", c_in_ready, 1'b0);
    chk("c_rst_data", c_out, 16'h0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    c_rst = 1'b1;

    // Full frame, continuous ready, then under alternating backpressure.
    run_frame_a(1'b0, 16);
    run_frame_a(1'b1, 16);

    // Upstream silent: border words drain, then stall at the first interior pixel.
    reset_a();
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) begin
        chk("a_stall_zero", a_out, 8'h0);
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    chk("a_stall_count", 64'(cnt), 64'd5);
    chk("a_stall_valid", a_out_valid, 1'b0);
    chk("a_stall_in_ready", a_in_ready, 1'b1);

    // Mid-frame reset lands on an interior beat; outputs must drop at once.
    reset_a();
    run_frame_a(1'b0, 6);
    a_in_valid  = 1'b1;
    a_in        = 8'h77;
    a_out_ready = 1'b1;
    #2;
    a_rst = 1'b0;
    #1;
    chk("a_midrst_valid", a_out_valid, 1'b0);
    chk("a_midrst_in_ready", a_in_ready, 1'b0);
    chk("a_midrst_data", a_out, 8'h0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    run_frame_a(1'b0, 16);

    // Zero padding: same-cycle pass-through.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] v;
      logic        vv;
      logic        rr;
      v  = 16'(32'h1000 + i * 37);
      vv = (i % 3) != 0;
      rr = (i % 4) != 1;
      c_in        = v;
      c_in_valid  = vv;
      c_out_ready = rr;
      #1;
      chk("c_data", c_out, v);
      chk("c_valid", c_out_valid, vv);
      chk("c_in_ready", c_in_ready, rr);
      @(posedge clk);
      #1;
    end

    // Wait for the streaming checks on DUT B.
    for (int i = 0; i < 3000 && !b_finished; i++) @(posedge clk);
    chk("b_finished", b_finished, 1'b1);
    chk("b_done", b_done, 1'b1);
    cnt = 0;
    for (int k = 0; k < 60; k++) if (b_interior(k)) cnt++;
    chk("b_model_interior", 64'(cnt), 64'd24);
    chk("b_outputs", 64'(b_outs), 64'd120);
    chk("b_inputs", 64'(b_src_idx), 64'd48);
    chk("b_log_13", b_log[13], 32'h0);
    chk("b_log_14", b_log[14], 32'hA000_0000);
    chk("b_log_45", b_log[45], 32'hA000_0017);
    chk("b_log_60", b_log[60], 32'h0);
    chk("b_log_74", b_log[74], 32'hA000_0018);
    chk("b_log_105", b_log[105], 32'hA000_002F);
    chk("b_log_119", b_log[119], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
